// File: rtl/pairing_pkg.sv
// Shared encodings for the pairing core: host modes, bank ids, opcodes, FSM states
// and helpers that locate the fields inside a command word.
package pairing_pkg;

  typedef enum logic [1:0] {
    INPUT_COORD_CORE = 2'd0,
    INPUT_CMD_CORE   = 2'd1,
    EXEC_CORE        = 2'd2,
    REF_RESULT       = 2'd3
  } mode_t;

  localparam logic inst_ML = 1'b0;
  localparam logic inst_FE = 1'b1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_COPY = 4'd4;
  localparam logic [3:0] OP_END  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_OPRD, ST_EXEC, ST_WB, ST_DONE
  } state_t;

  // Command layout, MSB first: opcode | dst | src1 | src2.
  function automatic int op_lsb(input int addr_w);
    return 3 * addr_w;
  endfunction

  function automatic int dst_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int src1_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int src2_lsb(input int addr_w);
    return 0 * addr_w;
  endfunction

endpackage

// File: rtl/pairing_modmul.sv
// Serial modular multiplier: MSB-first double-and-add, one multiplier bit per cycle.
// start captures bit WORD_SIZE-1; done is high in the cycle that consumes bit 0.
module pairing_modmul
  import pairing_pkg::*;
#(
  parameter int                   WORD_SIZE = 381,
  parameter logic [WORD_SIZE-1:0] MODULUS   = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result
);

  localparam int IDX_W = $clog2(WORD_SIZE);

  logic [WORD_SIZE-1:0] r_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 busy_reg;

  function automatic logic [WORD_SIZE-1:0] step(input logic [WORD_SIZE-1:0] r,
                                                input logic [WORD_SIZE-1:0] x,
                                                input logic             bit_v);
    logic [WORD_SIZE:0]   dbl;
    logic [WORD_SIZE-1:0] r2;
    logic [WORD_SIZE:0]   s;
    dbl = {r, 1'b0};
    r2  = (dbl >= {1'b0, MODULUS}) ? ({r[WORD_SIZE-2:0], 1'b0} - MODULUS)
                                   : {r[WORD_SIZE-2:0], 1'b0};
    s   = {1'b0, r2} + {1'b0, x};
    if (!bit_v) return r2;
    return (s >= {1'b0, MODULUS}) ? (r2 + x - MODULUS) : s[WORD_SIZE-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg    <= '0;
      idx_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      r_reg    <= step('0, a, b[WORD_SIZE-1]);
      idx_reg  <= IDX_W'(WORD_SIZE - 2);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      r_reg   <= step(r_reg, a, b[idx_reg]);
      idx_reg <= idx_reg - 1'b1;
      if (idx_reg == '0) busy_reg <= 1'b0;
    end
  end

  // A restart must never see a stale done from an aborted run.
  assign done   = busy_reg && !start && (idx_reg == '0);
  assign result = r_reg;

endmodule

// File: rtl/pairing_top.sv
// Programmable modular-arithmetic core: data RAM, ML/FE command banks, command FSM.
// Define PAIRING_TOP_MODMUL_EN to build the serial multiplier; otherwise MUL acts as NOP.
module pairing_top
  import pairing_pkg::*;
#(
  parameter int                   WORD_SIZE     = 381,
  parameter logic [WORD_SIZE-1:0] MODULUS       = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
  parameter int                   RAM_ADDR_SIZE = 8,
  parameter int                   CMD_MEMSIZE   = 9,
  parameter int                   CMD_SIZE      = 4 + 3 * RAM_ADDR_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               I_INPUTMODE,
  input  logic                     I_INSTTYPE,
  input  logic [CMD_MEMSIZE-1:0]   I_MODE_WADDR,
  input  logic [CMD_SIZE-1:0]      I_MODE_WDATA,
  input  logic [RAM_ADDR_SIZE-1:0] I_WADDR1,
  input  logic [RAM_ADDR_SIZE-1:0] I_WADDR2,
  input  logic [WORD_SIZE-1:0]     I_WDATA1,
  input  logic [WORD_SIZE-1:0]     I_WDATA2,
  input  logic [RAM_ADDR_SIZE-1:0] I_RADDR1,
  input  logic [RAM_ADDR_SIZE-1:0] I_RADDR2,
  output logic [WORD_SIZE-1:0]     outdata1,
  output logic [WORD_SIZE-1:0]     outdata2,
  output logic                     is_busy
);

  localparam int A     = RAM_ADDR_SIZE;
  localparam int OP_LO = op_lsb(A);
  localparam int DS_LO = dst_lsb(A);
  localparam int S1_LO = src1_lsb(A);
  localparam int S2_LO = src2_lsb(A);

  logic [WORD_SIZE-1:0] ram     [2**RAM_ADDR_SIZE];
  logic [CMD_SIZE-1:0]  cmd_mem [2**(CMD_MEMSIZE+1)];

  mode_t                mode, prev_mode_reg;
  state_t               state_reg, state_next;
  logic                 bank_reg, exec_entry, write_op, wb_en;
  logic [CMD_MEMSIZE-1:0] pc_reg;
  logic [CMD_SIZE-1:0]  cmd_reg;
  logic [3:0]           cmd_op, op_reg;
  logic [A-1:0]         cmd_dst, cmd_src1, cmd_src2, dst_reg;
  logic [WORD_SIZE-1:0] opa_reg, opb_reg, result_reg, alu_result, wb_data;
  logic [WORD_SIZE-1:0] sum_red, diff_fix, mul_result;
  logic [WORD_SIZE:0]   sum, diff;
  logic                 mul_done;

  assign mode       = mode_t'(I_INPUTMODE);
  assign exec_entry = (mode == EXEC_CORE) && (prev_mode_reg != EXEC_CORE);
  assign cmd_op     = cmd_reg[OP_LO +: 4];
  assign cmd_dst    = cmd_reg[DS_LO +: A];
  assign cmd_src1   = cmd_reg[S1_LO +: A];
  assign cmd_src2   = cmd_reg[S2_LO +: A];

`ifdef PAIRING_TOP_MODMUL_EN
  localparam bit MUL_EN = 1'b1;
  logic exec_first_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exec_first_reg <= 1'b0;
    else     exec_first_reg <= (state_reg == ST_OPRD) && (state_next == ST_EXEC);
  end

  pairing_modmul #(.WORD_SIZE(WORD_SIZE), .MODULUS(MODULUS)) u_modmul (
    .clk    (clk),
    .rst    (rst),
    .start  (exec_first_reg && (op_reg == OP_MUL)),
    .a      (opa_reg),
    .b      (opb_reg),
    .done   (mul_done),
    .result (mul_result)
  );
`else
  localparam bit MUL_EN = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = '0;
`endif

  always_comb begin
    state_next = state_reg;
    if (mode != EXEC_CORE) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (exec_entry) state_next = ST_FETCH;
        ST_FETCH: state_next = ST_OPRD;
        ST_OPRD:  state_next = (cmd_op == OP_END) ? ST_DONE : ST_EXEC;
        ST_EXEC:  if (op_reg != OP_MUL || !MUL_EN || mul_done) state_next = ST_WB;
        ST_WB:    state_next = ST_FETCH;
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Operands are below MODULUS, so one conditional correction suffices.
  always_comb begin
    sum        = {1'b0, opa_reg} + {1'b0, opb_reg};
    diff       = {1'b0, opa_reg} - {1'b0, opb_reg};
    sum_red    = opa_reg + opb_reg - MODULUS;
    diff_fix   = opa_reg - opb_reg + MODULUS;
    alu_result = opa_reg;
    case (op_reg)
      OP_ADD:  alu_result = (sum >= {1'b0, MODULUS}) ? sum_red : sum[WORD_SIZE-1:0];
      OP_SUB:  alu_result = diff[WORD_SIZE] ? diff_fix : diff[WORD_SIZE-1:0];
      default: alu_result = opa_reg;
    endcase
  end

  assign write_op = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_COPY) ||
                    (MUL_EN && (op_reg == OP_MUL));
  assign wb_en    = (mode == EXEC_CORE) && (state_reg == ST_WB) && write_op;
  assign wb_data  = (op_reg == OP_MUL) ? mul_result : result_reg;
  assign is_busy  = (state_reg inside {ST_FETCH, ST_OPRD, ST_EXEC, ST_WB}) &&
                    !((state_reg == ST_OPRD) && (cmd_op == OP_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      prev_mode_reg <= INPUT_COORD_CORE;
      bank_reg      <= inst_ML;
      pc_reg        <= '0;
      op_reg        <= OP_NOP;
      dst_reg       <= '0;
      result_reg    <= '0;
      outdata1      <= '0;
      outdata2      <= '0;
    end else begin
      state_reg     <= state_next;
      prev_mode_reg <= mode;
      if (exec_entry) begin
        bank_reg <= I_INSTTYPE;
        pc_reg   <= '0;
      end else if (state_reg == ST_OPRD && cmd_op != OP_END) begin
        pc_reg   <= pc_reg + 1'b1;
      end
      if (state_reg == ST_OPRD) begin
        op_reg  <= cmd_op;
        dst_reg <= cmd_dst;
      end
      if (state_reg == ST_EXEC) result_reg <= alu_result;
      if (mode == REF_RESULT) begin
        outdata1 <= ram[I_RADDR1];
        outdata2 <= ram[I_RADDR2];
      end
    end
  end

  // Port 2 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (mode == INPUT_COORD_CORE) begin
      ram[I_WADDR1] <= I_WDATA1;
      ram[I_WADDR2] <= I_WDATA2;
    end else if (wb_en) begin
      ram[dst_reg] <= wb_data;
    end
    if (state_reg == ST_OPRD) begin
      opa_reg <= ram[cmd_src1];
      opb_reg <= ram[cmd_src2];
    end
  end

  always_ff @(posedge clk) begin
    if (mode == INPUT_CMD_CORE) cmd_mem[{I_INSTTYPE, I_MODE_WADDR}] <= I_MODE_WDATA;
    cmd_reg <= cmd_mem[{bank_reg, pc_reg}];
  end

endmodule

// File: tb/tb_pairing_top.sv
// Scoreboard bench for pairing_top with WORD_SIZE=8, MODULUS=97: expected RAM contents
// are queued when a program is loaded and popped as readback data arrives.
module tb_pairing_top;

`ifdef PAIRING_TOP_MODMUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        insttype;
  logic [3:0]  mode_waddr;
  logic [15:0] mode_wdata;
  logic [3:0]  waddr1, waddr2, raddr1, raddr2;
  logic [7:0]  wdata1, wdata2, outdata1, outdata2;
  logic        is_busy;

  int          n_vec = 0;
  int          n_err = 0;
  string       q_name[$];
  logic [7:0]  q_val[$];
  string       e_name;
  logic [7:0]  e_val, d1, d2;
  int          busy_cnt;
  bit          timed_out;

  always #5 clk = ~clk;

  pairing_top #(
    .WORD_SIZE(8), .MODULUS(8'd97), .RAM_ADDR_SIZE(4), .CMD_MEMSIZE(4)
  ) dut (
    .clk(clk), .rst(rst), .I_INPUTMODE(mode), .I_INSTTYPE(insttype),
    .I_MODE_WADDR(mode_waddr), .I_MODE_WDATA(mode_wdata),
    .I_WADDR1(waddr1), .I_WADDR2(waddr2), .I_WDATA1(wdata1), .I_WDATA2(wdata2),
    .I_RADDR1(raddr1), .I_RADDR2(raddr2),
    .outdata1(outdata1), .outdata2(outdata2), .is_busy(is_busy)
  );

  task automatic push_exp(input string n, input logic [7:0] v);
    q_name.push_back(n);
    q_val.push_back(v);
  endtask

  task automatic pop_exp();
    e_name = q_name.pop_front();
    e_val  = q_val.pop_front();
  endtask

  task automatic write_data(input logic [3:0] a1, input logic [7:0] v1,
                            input logic [3:0] a2, input logic [7:0] v2);
    @(negedge clk);
    mode = 2'd0; waddr1 = a1; wdata1 = v1; waddr2 = a2; wdata2 = v2;
    @(negedge clk);
    mode = 2'd3;
  endtask

  task automatic write_cmd(input logic b, input logic [3:0] a, input logic [15:0] c);
    @(negedge clk);
    mode = 2'd1; insttype = b; mode_waddr = a; mode_wdata = c;
    @(negedge clk);
    mode = 2'd3;
  endtask

  task automatic do_read(input logic [3:0] a1, input logic [3:0] a2);
    @(negedge clk);
    mode = 2'd3; raddr1 = a1; raddr2 = a2;
    @(negedge clk);
    d1 = outdata1; d2 = outdata2;
    $display("read  [%0d]=%0d [%0d]=%0d", a1, d1, a2, d2);
  endtask

  task automatic run_prog(input logic b);
    @(negedge clk);
    insttype = b; mode = 2'd2;
    busy_cnt = 0; timed_out = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (is_busy) busy_cnt++;
      else if (busy_cnt > 0) begin timed_out = 1'b0; break; end
    end
    mode = 2'd3;
    $display("exec  bank=%0d busy_cycles=%0d timeout=%0d", b, busy_cnt, timed_out);
  endtask

  task automatic compare_pair();
    pop_exp(); n_vec++;
    if (d1 !== e_val) begin n_err++; $display("FAIL %s: got %0d expected %0d", e_name, d1, e_val); end
    pop_exp(); n_vec++;
    if (d2 !== e_val) begin n_err++; $display("FAIL %s: got %0d expected %0d", e_name, d2, e_val); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (is_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", is_busy); end
    n_vec++;
    if (outdata1 !== 8'd0) begin n_err++; $display("FAIL reset_out1: got %0d expected 0", outdata1); end
    n_vec++;
    if (outdata2 !== 8'd0) begin n_err++; $display("FAIL reset_out2: got %0d expected 0", outdata2); end
    $display("reset busy=%b out1=%0d out2=%0d", is_busy, outdata1, outdata2);
    rst = 1'b0;
  endtask

  task automatic test_load_readback();
    write_data(4'd0, 8'd60, 4'd1, 8'd50);
    push_exp("load_ram0", 8'd60); push_exp("load_ram1", 8'd50);
    do_read(4'd0, 4'd1);
    compare_pair();
  endtask

  task automatic test_add_sub();
    write_cmd(1'b0, 4'd0, 16'h1201);
    write_cmd(1'b0, 4'd1, 16'h2321);
    write_cmd(1'b0, 4'd2, 16'hF000);
    push_exp("add_ram2", 8'd13); push_exp("sub_ram3", 8'd60);
    run_prog(1'b0);
    n_vec++;
    if (timed_out || busy_cnt != 9) begin
      n_err++; $display("FAIL addsub_busy: got %0d cycles (timeout=%0d) expected 9", busy_cnt, timed_out);
    end
    do_read(4'd2, 4'd3);
    compare_pair();
  endtask

  task automatic test_mul();
    write_data(4'd4, 8'd3, 4'd5, 8'd7);
    write_cmd(1'b0, 4'd0, 16'h3514);
    write_cmd(1'b0, 4'd1, 16'hF000);
    push_exp("mul_ram5", MUL_EN ? 8'd53 : 8'd7); push_exp("mul_ram4", 8'd3);
    run_prog(1'b0);
    n_vec++;
    if (timed_out || busy_cnt != (MUL_EN ? 12 : 5)) begin
      n_err++; $display("FAIL mul_busy: got %0d cycles expected %0d", busy_cnt, MUL_EN ? 12 : 5);
    end
    do_read(4'd5, 4'd4);
    compare_pair();
  endtask

  task automatic test_port_collision();
    write_data(4'd6, 8'd11, 4'd6, 8'd22);
    write_data(4'd7, 8'd33, 4'd8, 8'd44);
    push_exp("coll_ram6", 8'd22); push_exp("port2_ram8", 8'd44);
    do_read(4'd6, 4'd8);
    compare_pair();
    push_exp("port1_ram7", 8'd33); push_exp("coll_ram6_b", 8'd22);
    do_read(4'd7, 4'd6);
    compare_pair();
  endtask

  task automatic test_bank_select();
    write_data(4'd9, 8'd1, 4'd10, 8'd2);
    write_cmd(1'b0, 4'd0, 16'h4900);
    write_cmd(1'b0, 4'd1, 16'hF000);
    write_cmd(1'b1, 4'd0, 16'h1A00);
    write_cmd(1'b1, 4'd1, 16'hF000);
    push_exp("fe_ram9_kept", 8'd1); push_exp("fe_ram10", 8'd23);
    run_prog(1'b1);
    do_read(4'd9, 4'd10);
    compare_pair();
    push_exp("ml_copy_ram9", 8'd60); push_exp("ml_ram10_kept", 8'd23);
    run_prog(1'b0);
    do_read(4'd9, 4'd10);
    compare_pair();
  endtask

  task automatic test_boundaries();
    write_data(4'd11, 8'd40, 4'd13, 8'd37);
    write_cmd(1'b0, 4'd0, 16'h1BBB);
    write_cmd(1'b0, 4'd1, 16'h2C00);
    write_cmd(1'b0, 4'd2, 16'h1E0D);
    write_cmd(1'b0, 4'd3, 16'hF000);
    push_exp("dst_eq_src", 8'd80); push_exp("sub_zero", 8'd0);
    push_exp("add_eq_p", 8'd0);    push_exp("ram13_kept", 8'd37);
    run_prog(1'b0);
    do_read(4'd11, 4'd12);
    compare_pair();
    do_read(4'd14, 4'd13);
    compare_pair();
  endtask

  task automatic test_abort_restart();
    write_data(4'd11, 8'd5, 4'd11, 8'd5);
    write_cmd(1'b0, 4'd0, 16'h1BBB);
    write_cmd(1'b0, 4'd1, 16'h1BBB);
    write_cmd(1'b0, 4'd2, 16'hF000);
    @(negedge clk);
    insttype = 1'b0; mode = 2'd2;
    repeat (5) @(negedge clk);
    mode = 2'd3;
    @(negedge clk);
    n_vec++;
    if (is_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", is_busy); end
    push_exp("abort_ram11", 8'd10); push_exp("abort_ram11_b", 8'd10);
    do_read(4'd11, 4'd11);
    compare_pair();
    push_exp("restart_ram11", 8'd40); push_exp("restart_ram0", 8'd60);
    run_prog(1'b0);
    do_read(4'd11, 4'd0);
    compare_pair();
  endtask

  task automatic test_reset_mid_mul();
    write_data(4'd5, 8'd7, 4'd4, 8'd3);
    write_cmd(1'b0, 4'd0, 16'h3514);
    write_cmd(1'b0, 4'd1, 16'hF000);
    push_exp("pre_rst_ram0", 8'd60); push_exp("pre_rst_ram1", 8'd50);
    do_read(4'd0, 4'd1);
    compare_pair();
    @(negedge clk);
    insttype = 1'b0; mode = 2'd2;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    $display("rst   mid-exec busy=%b out1=%0d out2=%0d", is_busy, outdata1, outdata2);
    n_vec++;
    if (is_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", is_busy); end
    n_vec++;
    if (outdata1 !== 8'd0) begin n_err++; $display("FAIL rst_mid_out1: got %0d expected 0", outdata1); end
    n_vec++;
    if (outdata2 !== 8'd0) begin n_err++; $display("FAIL rst_mid_out2: got %0d expected 0", outdata2); end
    @(negedge clk);
    rst = 1'b0; mode = 2'd3;
    push_exp("rst_ram5_kept", 8'd7); push_exp("rst_ram0_kept", 8'd60);
    do_read(4'd5, 4'd0);
    compare_pair();
    push_exp("rerun_ram5", MUL_EN ? 8'd53 : 8'd7); push_exp("rerun_ram4", 8'd3);
    run_prog(1'b0);
    n_vec++;
    if (timed_out) begin n_err++; $display("FAIL rerun_timeout: got timeout expected completion"); end
    do_read(4'd5, 4'd4);
    compare_pair();
  endtask

  initial begin
    rst = 1'b1; mode = 2'd3; insttype = 1'b0;
    mode_waddr = '0; mode_wdata = '0;
    waddr1 = '0; waddr2 = '0; wdata1 = '0; wdata2 = '0; raddr1 = '0; raddr2 = '0;
    test_reset();
    test_load_readback();
    test_add_sub();
    test_mul();
    test_port_collision();
    test_bank_select();
    test_boundaries();
    test_abort_restart();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pairing_top.md
# pairing_top

Programmable modular-arithmetic core for the BLS12 pairing datapath. It holds a two-port data RAM of field elements and two command banks: Miller loop (ML) and final exponentiation (FE). It executes a stored command program over the RAM and exposes results through two registered read ports. A host sequences it through four input modes: load data, load commands, execute, read back.

## Interface
- WORD_SIZE, 381: field-element width.
- MODULUS, BLS12-381 p: prime modulus; must satisfy MODULUS < 2^WORD_SIZE.
- RAM_ADDR_SIZE, 8: data RAM address width (2^RAM_ADDR_SIZE words).
- CMD_MEMSIZE, 9: command address width per bank.
- CMD_SIZE, 4+3*RAM_ADDR_SIZE: command word width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- I_INPUTMODE  in  2  0=INPUT_COORD_CORE, 1=INPUT_CMD_CORE, 2=EXEC_CORE, 3=REF_RESULT.
- I_INSTTYPE  in  1  bank select: 0=inst_ML, 1=inst_FE.
- I_MODE_WADDR  in  CMD_MEMSIZE  command write address.
- I_MODE_WDATA  in  CMD_SIZE  command write data.
- I_WADDR1, I_WADDR2  in  RAM_ADDR_SIZE  data write addresses.
- I_WDATA1, I_WDATA2  in  WORD_SIZE  data write values.
- I_RADDR1, I_RADDR2  in  RAM_ADDR_SIZE  result read addresses.
- outdata1, outdata2  out  WORD_SIZE  registered read data.
- is_busy  out  1  program running.

## Operation
- INPUT_COORD_CORE: every cycle, ram[I_WADDR1]<=I_WDATA1 and ram[I_WADDR2]<=I_WDATA2. On equal addresses, port 2 wins.
- INPUT_CMD_CORE: every cycle, bank[I_INSTTYPE][I_MODE_WADDR]<=I_MODE_WDATA.
- EXEC_CORE: on entry (previous mode differs), latch I_INSTTYPE, PC=0, start the FSM. Host RAM and command writes are ignored.
- REF_RESULT: outdata1<=ram[I_RADDR1] and outdata2<=ram[I_RADDR2] each cycle. In other modes outdata holds.
- Command fields: [CMD_SIZE-1 -: 4] opcode, then dst, src1, src2. Opcodes:
  - 0 NOP.
  - 1 ADD: (a+b) mod P.
  - 2 SUB: (a-b) mod P.
  - 3 MUL: a*b mod P.
  - 4 COPY: dst=a.
  - 15 END.
  - Others act as NOP.
- ADD and SUB use a WORD_SIZE+1 internal width with a single conditional correction. Operands must be < P; results are then < P.
- MUL uses an MSB-first interleaved double-and-add: r=2r mod P, then if b[i], r=r+a mod P. One bit per cycle.
- FSM: IDLE -> FETCH -> OPRD -> EXEC (1 cycle; MUL runs WORD_SIZE cycles) -> WB -> FETCH.
  - OPRD decoding END goes to DONE.
  - DONE holds until the mode leaves EXEC_CORE, then goes to IDLE.
  - Leaving EXEC_CORE in any state aborts to IDLE. A write in flight is not performed.
- PC wraps from 2^CMD_MEMSIZE-1 to 0.
- dst equal to src is legal: operands are captured before write-back.

## Timing
- Reset: FSM IDLE, is_busy=0, outdata1/2=0, PC=0. RAM and command memories are not cleared.
- Readback latency is 1 cycle: the address presented at edge k appears after edge k+1.
- is_busy goes high the cycle after EXEC_CORE entry. It falls the cycle after END reaches OPRD.
- Cycles per command: NOP/ADD/SUB/COPY take 4 (FETCH, OPRD, EXEC, WB). MUL takes 3+WORD_SIZE.
- The write-back result is visible to the next command's OPRD.

## Configuration
- PAIRING_TOP_MODMUL_EN defined: MUL opcode implemented as above.
- Not defined: multiplier omitted, MUL executes as NOP (4 cycles, no write).

## Structure
- Shared package pairing_pkg: mode encodings, inst_ML/inst_FE, opcode constants, FSM state enum, command-field offset functions.
- One sub-module: pairing_modmul (start/done handshake, WORD_SIZE-cycle serial modular multiplier). ADD/SUB/COPY stay inline.

## Test plan
Bench settings: WORD_SIZE=8, MODULUS=97, RAM_ADDR_SIZE=4, CMD_MEMSIZE=4.
- Load ram[0]=60, ram[1]=50 via both write ports. REF_RESULT addr 0/1 -> outdata1=60, outdata2=50 one cycle later.
- Program ML bank: ADD 2,0,1; SUB 3,2,1 (dst=3, 13-50); END. Execute, wait for is_busy=0 -> ram[2]=13, ram[3]=60; busy for 9 cycles.
- With MODMUL_EN: ram[4]=3, MUL 5,1,4; END -> ram[5]=53 (150 mod 97). Without it -> ram[5] unchanged.
- Both write ports target address 6 with 11 and 22 -> readback 22.
- Load distinct programs into ML and FE. Select I_INSTTYPE=1 -> only the FE program's results change.
- Assert rst mid-MUL -> is_busy=0 and outdata=0 immediately. A re-entered EXEC restarts at PC=0.
